// File: rtl/gamma_pkg.sv
// gamma_pkg: shared definitions for the gamma correction pipeline.
//   - default IN_W / OUT_W / CHANNELS values
//   - chan_lsb(): bit offset of channel c in a packed multi-channel word
//   - init_state_t: table initialisation FSM states (INIT, RUN)
package gamma_pkg;

  localparam int DEF_IN_W     = 8;
  localparam int DEF_OUT_W    = 8;
  localparam int DEF_CHANNELS = 3;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } init_state_t;

  // Channel c of a packed word of width-bit channels lives at [c*width +: width].
  function automatic int chan_lsb(input int c, input int width);
    return c * width;
  endfunction

endpackage

// File: rtl/gamma_lut_ram.sv
// gamma_lut_ram: one channel's gamma table, 2^ADDR_W x DATA_W simple dual-port
// RAM with synchronous, enabled read. A write and a read to the same address in
// the same cycle return the old contents (read-first).
// Ports:
//   clk    - clock
//   we     - write strobe;  waddr / wdata - write address / data
//   re     - read enable;   raddr - read address
//   rdata  - registered read data, held while re is low
module gamma_lut_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  // Both accesses in one process with non-blocking writes: the read sees the
  // pre-write contents, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/gamma_pipe.sv
// gamma_pipe: multi-channel runtime-programmable gamma correction stage.
// After reset every table is filled with a linear curve (entry k = k << (OUT_W-IN_W)),
// one entry per cycle; afterwards pixels stream through a 2-stage valid/ready
// pipeline (table read, output register) and tables can be rewritten via cfg_*.
// Optional build macro GAMMA_BYPASS_EN adds the per-pixel 'bypass' input which
// outputs the zero-extended input channel instead of the table value.
// Ports:
//   clk, rst_n                   - clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_last     - input pixel stream (+ row-end flag)
//   out_valid/out_ready/out_data/out_last - corrected pixel stream
//   cfg_we/cfg_chan/cfg_addr/cfg_data     - table write port
//   cfg_ready                    - table writes accepted (RUN state)
//   init_busy                    - linear-curve initialisation in progress
//   bypass (GAMMA_BYPASS_EN only)- pass the pixel through uncorrected
module gamma_pipe
  import gamma_pkg::*;
#(
  parameter int IN_W     = DEF_IN_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int CHANNELS = DEF_CHANNELS,
  localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*IN_W-1:0]  in_data,
  input  logic                      in_last,
`ifdef GAMMA_BYPASS_EN
  input  logic                      bypass,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*OUT_W-1:0] out_data,
  output logic                      out_last,
  input  logic                      cfg_we,
  input  logic [CHAN_W-1:0]         cfg_chan,
  input  logic [IN_W-1:0]           cfg_addr,
  input  logic [OUT_W-1:0]          cfg_data,
  output logic                      cfg_ready,
  output logic                      init_busy
);

  localparam int PAD = OUT_W - IN_W;

  // ---------------- initialisation FSM ----------------
  init_state_t     state, state_next;
  logic [IN_W-1:0] init_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) init_cnt <= init_cnt + IN_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    init_busy  = 1'b1;
    cfg_ready  = 1'b0;
    case (state)
      INIT: if (init_cnt == {IN_W{1'b1}}) state_next = RUN;
      RUN: begin
        init_busy = 1'b0;
        cfg_ready = 1'b1;
      end
      default: state_next = INIT;
    endcase
  end

  // ---------------- handshake ----------------
  logic adv, accept;
  assign adv      = !out_valid || out_ready;
  assign in_ready = cfg_ready && adv;
  assign accept   = in_valid && in_ready;

  // ---------------- table write path ----------------
  // During INIT all tables share the linear-curve write; in RUN only the
  // addressed table is written, and an out-of-range channel matches none.
  logic [IN_W-1:0]  wr_addr;
  logic [OUT_W-1:0] wr_data;
  assign wr_addr = init_busy ? init_cnt : cfg_addr;
  assign wr_data = init_busy ? (OUT_W'(init_cnt) << PAD) : cfg_data;

  // ---------------- stage 1 ----------------
  logic s1_valid, s1_last;
`ifdef GAMMA_BYPASS_EN
  logic                     s1_bypass;
  logic [CHANNELS*IN_W-1:0] s1_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
`ifdef GAMMA_BYPASS_EN
      s1_bypass <= 1'b0;
      s1_raw    <= '0;
`endif
    end else if (adv) begin
      s1_valid <= accept;
      s1_last  <= in_last;
`ifdef GAMMA_BYPASS_EN
      s1_bypass <= bypass;
      s1_raw    <= in_data;
`endif
    end
  end

  // ---------------- per-channel tables ----------------
  logic [CHANNELS*OUT_W-1:0] corr_data;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      localparam int IN_LSB  = chan_lsb(gi, IN_W);
      localparam int OUT_LSB = chan_lsb(gi, OUT_W);
      logic             lut_we;
      logic [OUT_W-1:0] lut_rd;

      assign lut_we = init_busy || (cfg_ready && cfg_we && (cfg_chan == CHAN_W'(gi)));

      gamma_lut_ram #(
        .ADDR_W (IN_W),
        .DATA_W (OUT_W)
      ) u_lut (
        .clk   (clk),
        .we    (lut_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .re    (accept),
        .raddr (in_data[IN_LSB +: IN_W]),
        .rdata (lut_rd)
      );

`ifdef GAMMA_BYPASS_EN
      assign corr_data[OUT_LSB +: OUT_W] = s1_bypass ? (OUT_W'(s1_raw[IN_LSB +: IN_W]) << PAD)
                                                     : lut_rd;
`else
      assign corr_data[OUT_LSB +: OUT_W] = lut_rd;
`endif
    end
  endgenerate

  // ---------------- stage 2 (output register) ----------------
  // Data/last load only with a real pixel so idle bubbles never expose stale reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= corr_data;
        out_last <= s1_last;
      end
    end
  end

endmodule

// File: tb/tb_gamma_pipe.sv
// tb_gamma_pipe: randomized scoreboard bench for gamma_pipe (default parameters).
// A driver pushes the expected corrected pixel (from a plain table model) into
// a queue whenever the DUT accepts a pixel; a monitor pops and compares on
// every output transfer.
module tb_gamma_pipe;
  localparam int CH  = 3;
  localparam int IW  = 8;
  localparam int OW  = 8;
  localparam int DEP = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CH*IW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [CH*OW-1:0] out_data;
  logic          out_last;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_chan = '0;
  logic [IW-1:0] cfg_addr = '0;
  logic [OW-1:0] cfg_data = '0;
  logic          cfg_ready;
  logic          init_busy;

  gamma_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
`ifdef GAMMA_BYPASS_EN
    .bypass    (1'b0),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .cfg_we    (cfg_we),
    .cfg_chan  (cfg_chan),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH*OW-1:0] d;
    logic             l;
  } exp_t;

  exp_t          sbq[$];
  logic [CH*OW-1:0] hist[$];
  logic [OW-1:0] lut[CH][DEP];
  int            checks = 0;
  int            errors = 0;
  int            mon_count = 0;
  bit            rand_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic model_linear();
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < DEP; k++) lut[c][k] = OW'(k);
  endtask

  // Downstream readiness, changed once per cycle away from the active edge.
  always @(negedge clk) out_ready = rand_mode ? (($urandom % 3) != 0) : 1'b1;

  // Monitor: an output transfer happens at the next posedge when valid && ready.
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      mon_count++;
      hist.push_back(out_data);
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got data=%h last=%0b, expected none", out_data, out_last);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (out_data !== e.d || out_last !== e.l) begin
          errors++;
          $display("FAIL pixel_out: got data=%h last=%0b, expected data=%h last=%0b",
                   out_data, out_last, e.d, e.l);
        end
      end
    end
  end

  // One cycle of stimulus: pixel offer and/or table write; returns whether the pixel was accepted.
  task automatic cycle(input bit pv, input logic [CH*IW-1:0] pd, input bit pl,
                       input bit we, input logic [1:0] ch, input logic [7:0] ad,
                       input logic [7:0] wd, output bit acc);
    @(negedge clk);
    in_valid = pv; in_data = pd; in_last = pl;
    cfg_we = we; cfg_chan = ch; cfg_addr = ad; cfg_data = wd;
    #1;
    acc = pv && in_ready;
    if (acc) begin
      exp_t e;
      for (int c = 0; c < CH; c++) e.d[c*OW +: OW] = lut[c][pd[c*IW +: IW]];
      e.l = pl;
      sbq.push_back(e);
    end
    // Table update after the lookup: same-cycle pixel sees the old entry.
    if (we && cfg_ready && ch < CH) lut[ch][ad] = wd;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
  endtask

  task automatic send(input logic [CH*IW-1:0] pd, input bit pl, output int tries);
    bit acc;
    tries = 0;
    do begin
      cycle(1'b1, pd, pl, 1'b0, 2'd0, 8'd0, 8'd0, acc);
      tries++;
    end while (!acc && tries < 200);
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: got no acceptance, expected acceptance within 200 cycles");
    end
  endtask

  task automatic assert_reset();
    rst_n = 1'b0; in_valid = 1'b0; cfg_we = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_init_busy", 32'(init_busy), 32'd1);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_last",  32'(out_last),  32'd0);
    sbq.delete();
    model_linear();
    repeat (2) @(posedge clk);
  endtask

  // Release reset and count cycles until initialisation completes.
  task automatic release_and_count(input bit hold_valid, input logic [CH*IW-1:0] pd);
    int n;
    bit ready_bad;
    @(negedge clk);
    rst_n = 1'b1; in_valid = hold_valid; in_data = pd; in_last = 1'b0;
    n = 0; ready_bad = 1'b0;
    while (n < 1000) begin
      @(posedge clk); #1;
      n++;
      if (!init_busy) break;
      if (in_ready) ready_bad = 1'b1;
    end
    chk("init_cycles", 32'(n), 32'd256);
    chk("init_in_ready_low", 32'(ready_bad), 32'd0);
    chk("run_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("run_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    chk("drain_pending", 32'(sbq.size()), 32'd0);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish before 500us");
    $fatal(1);
  end

  initial begin
    bit acc;
    int tries;
    int run;
    bit seen;
    int cnt0;
    logic [CH*IW-1:0] pd;

    model_linear();

    // ---- reset, init with in_valid held, first pixel latency ----
    assert_reset();
    release_and_count(1'b1, 24'hFF8010);
    send(24'hFF8010, 1'b0, tries);
    chk("first_accept_tries", 32'(tries), 32'd1);
    chk("lat_stage1_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_stage2_out_valid", 32'(out_valid), 32'd1);
    chk("lat_stage2_out_data", 32'(out_data), 32'hFF8010);
    drain();

    // ---- ch1 inverted curve, 256-pixel ramp, no bubbles ----
    for (int a = 0; a < DEP; a++) cycle(1'b0, '0, 1'b0, 1'b1, 2'd1, 8'(a), 8'(8'hFF - a), acc);
    run = 0; seen = 1'b0;
    fork
      begin
        for (int i = 0; i < DEP; i++) begin
          send({8'(i), 8'(i), 8'(i)}, 1'b0, tries);
          if (tries != 1) begin
            errors++;
            $display("FAIL ramp_accept: got %0d tries, expected 1", tries);
          end
        end
      end
      begin
        for (int k = 0; k < 400; k++) begin
          @(negedge clk); #3;
          if (out_valid) begin seen = 1'b1; run++; end
          else if (seen) break;
        end
      end
    join
    chk("ramp_contiguous_valid", 32'(run), 32'd256);
    drain();

    // ---- 16 pixels, in_last every 4th, random backpressure ----
    rand_mode = 1'b1;
    cnt0 = mon_count;
    for (int i = 0; i < 16; i++) begin
      pd = CH*IW'($urandom);
      send(pd, (i % 4) == 3, tries);
      if ($urandom % 2) repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    drain();
    rand_mode = 1'b0;
    chk("bp_output_count", 32'(mon_count - cnt0), 32'd16);

    // ---- same-cycle write and read of ch0[0x40]: read-first ----
    repeat (2) @(posedge clk);
    hist.delete();
    cycle(1'b1, 24'h000040, 1'b0, 1'b1, 2'd0, 8'h40, 8'h99, acc);
    chk("rf_accept", 32'(acc), 32'd1);
    send(24'h000040, 1'b1, tries);
    drain();
    chk("rf_hist_count", 32'(hist.size()), 32'd2);
    if (hist.size() == 2) begin
      chk("rf_old_value", 32'(hist[0][7:0]), 32'h40);
      chk("rf_new_value", 32'(hist[1][7:0]), 32'h99);
    end

    // ---- random mix: pixels, writes (incl. out-of-range channel), backpressure ----
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ad;
      pd = CH*IW'($urandom);
      ad = ($urandom % 2) ? pd[7:0] : 8'($urandom);
      cycle(($urandom % 4) != 0, pd, 1'($urandom), ($urandom % 3) == 0,
            2'($urandom), ad, 8'($urandom), acc);
    end
    drain();
    rand_mode = 1'b0;
    cnt0 = mon_count;
    for (int i = 0; i < 8; i++) begin
      pd = CH*IW'($urandom);
      send(pd, 1'b0, tries);
    end
    drain();
    chk("post_mix_count", 32'(mon_count - cnt0), 32'd8);

    // ---- reset mid-stream, then mid-init ----
    rand_mode = 1'b1;
    for (int i = 0; i < 6; i++) send(CH*IW'($urandom), 1'b0, tries);
    #2;
    assert_reset();
    rand_mode = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #2;
    assert_reset();
    release_and_count(1'b0, '0);
    // Tables are linear again after the re-init.
    for (int i = 0; i < 4; i++) send({8'(i * 60), 8'(i * 7), 8'(255 - i)}, 1'b1, tries);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gamma_pipe.md
Name: gamma_pipe

Overview:
Multi-channel, runtime-programmable gamma correction stage between the frame buffer read path and the BCM/PWM shifter. Each channel has its own RAM lookup table of 2^IN_W entries × OUT_W bits. The block self-initialises to a linear curve after reset and is reloaded through a config write port. Pixels stream through a 2-stage valid/ready pipeline with full backpressure.

Parameters:
IN_W, 8, input bits per channel; table depth is 2^IN_W.
OUT_W, 8, output bits per channel; must be >= IN_W; wider values are for deeper BCM planes.
CHANNELS, 3, number of independent colour channels/tables.

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input pixel valid
in_ready  out  1  block accepts input this cycle
in_data  in  CHANNELS*IN_W  channel c at bits [c*IN_W +: IN_W]
in_last  in  1  end-of-row sideband, carried with the pixel
out_valid  out  1  output pixel valid
out_ready  in  1  downstream accepts output
out_data  out  CHANNELS*OUT_W  corrected channels, same packing
out_last  out  1  delayed in_last
cfg_we  in  1  table write strobe
cfg_chan  in  $clog2(CHANNELS) (min 1)  target table
cfg_addr  in  IN_W  entry index
cfg_data  in  OUT_W  entry value
cfg_ready  out  1  table writes are accepted (low during init)
init_busy  out  1  linear-curve initialisation is in progress

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_last=0, in_ready=0, cfg_ready=0, init_busy=1, init counter=0.
- Init FSM states: INIT, RUN.
  - INIT writes entry k = {k, (OUT_W-IN_W) zeros} to all CHANNELS tables in parallel, one entry per cycle.
  - After 2^IN_W cycles (k = 2^IN_W-1 written), INIT moves to RUN: init_busy=0, cfg_ready=1.
  - RUN is left only by reset. Reset mid-init restarts at k=0.
- Handshake: a transfer occurs when valid && ready on either side. in_ready = RUN && adv, where adv = !out_valid || out_ready. in_ready is not combinationally dependent on in_valid.
- Pipeline:
  - Stage 1: on an accepted input, the RAM read is issued with in_data. Stage-1 valid and last are registered.
  - Stage 2: on adv, the stage-1 read data is registered into out_data, and out_valid/out_last are updated.
  - Latency is exactly 2 cycles from input acceptance to out_valid when out_ready is held high. Throughput is 1 pixel/cycle.
  - When stalled (adv=0), RAM read enable is deasserted. Both stages hold their contents; no pixel is lost or duplicated.
- Config writes:
  - In RUN, cfg_we writes cfg_data to table cfg_chan[cfg_addr] at the clock edge.
  - cfg_chan >= CHANNELS: the write is ignored.
  - cfg_we in INIT: ignored (cfg_ready=0).
  - Write and read to the same entry in the same cycle: read-first, so the pixel gets the old value.
  - Writes are allowed while streaming. The new value affects pixels accepted from the next cycle on.
- Widths: no arithmetic on the data path. Out-of-range cfg fields are truncated to the port width.

Optional Feature:
GAMMA_BYPASS_EN
- Defined: adds input port bypass (1 bit), sampled with each accepted pixel and pipelined alongside it. When set for a pixel, out_data per channel = {in channel, (OUT_W-IN_W) zeros}. Latency and handshake are unchanged, and the tables are untouched.
- Undefined: the port is absent and all pixels go through the tables.

Decomposition:
- Shared package gamma_pkg holds:
  - default IN_W/OUT_W/CHANNELS constants
  - the channel packing helper function
  - the init FSM state enum (INIT, RUN)
- One natural sub-module: gamma_lut_ram, a single-channel 2^IN_W × OUT_W simple dual-port RAM with sync read, read enable, write port and read-first semantics. It is instantiated CHANNELS times via generate.

Test Plan:
- Reset, then hold in_valid=1: init_busy stays 1 and in_ready stays 0 for exactly 256 cycles (default params). Then pixel {R=0x10,G=0x80,B=0xFF} gives out {0x10,0x80,0xFF} 2 cycles after acceptance.
- Load table ch1 with out=0xFF-addr, then stream 256 ramp pixels with out_ready=1: ch1 output is the inverted ramp, ch0/ch2 are linear, and there are no gaps in out_valid.
- Stream 16 pixels with in_last on every 4th while toggling out_ready pseudo-randomly: output order, data and out_last match the input exactly, with no drops or duplicates.
- Same cycle: cfg_we to ch0[0x40]=0x99 and accept a pixel with R=0x40: that pixel outputs 0x40 (read-first), and the next R=0x40 pixel outputs 0x99.
- Assert rst_n=0 mid-stream and mid-init: out_valid drops immediately, and init restarts from k=0 taking a full 256 cycles.
- With GAMMA_BYPASS_EN and OUT_W=12: bypass=1 pixel R=0x80 gives 0x800 regardless of table contents. An interleaved bypass=0 pixel uses the table.
